// File: rtl/stepper_move_sequencer.sv
// rtl/stepper_move_sequencer.sv - commanded stepper moves with linear accel/cruise/decel ramp and post-move hold
module stepper_move_sequencer #(
  parameter int unsigned START_PERIOD = 50000,
  parameter int unsigned MIN_PERIOD   = 13500,
  parameter int unsigned ACCEL_DELTA  = 4000,
  parameter int unsigned STEP_W       = 16,
  parameter int unsigned HOLD_CYCLES  = 27000000,
  parameter logic [3:0]  RUN_VREF     = 4'd3,
  parameter logic [3:0]  HOLD_VREF    = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              abort,
  output logic              rotate_pulse,
  output logic              direction,
  output logic              module_enable,
  output logic [3:0]        vref_level,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_done
);

  localparam int unsigned PW = $clog2(START_PERIOD + 1);
  localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [PW-1:0] START_P   = PW'(START_PERIOD);
  localparam logic [PW-1:0] MIN_P     = PW'(MIN_PERIOD);
  localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     period, period_n;
  logic [PW-1:0]     cnt, cnt_n;
  logic [STEP_W-1:0] remaining, remaining_n;
  logic [STEP_W-1:0] ramp_steps, ramp_steps_n;
  logic [HW-1:0]     hold_cnt, hold_cnt_n;
  logic              abort_pend, abort_pend_n;
  logic              rotate_n, direction_n, enable_n, done_n;
  logic [3:0]        vref_n;
  logic [STEP_W-1:0] steps_done_n;

  logic              accept;
  logic              ramping;
  logic [STEP_W-1:0] rem_dec;
  logic [STEP_W-1:0] ramp_eff;
  logic [32:0]       per_inc_w;
  logic [PW-1:0]     per_up;
  logic [PW-1:0]     per_down;

  assign cmd_ready = (state == IDLE) || (state == HOLD);
  assign busy      = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
  assign accept    = cmd_valid && cmd_ready;
  assign ramping   = (state == ACCEL) || (state == CRUISE);

  // Saturating next periods computed from the period just used; widened to avoid wrap.
  assign per_inc_w = 33'(period) + 33'(ACCEL_DELTA);
  assign per_up    = (per_inc_w > 33'(START_PERIOD)) ? START_P : PW'(per_inc_w);
  assign per_down  = (33'(period) > 33'(MIN_PERIOD) + 33'(ACCEL_DELTA))
                     ? PW'(33'(period) - 33'(ACCEL_DELTA)) : MIN_P;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      period        <= START_P;
      cnt           <= '0;
      remaining     <= '0;
      ramp_steps    <= '0;
      hold_cnt      <= '0;
      abort_pend    <= 1'b0;
      rotate_pulse  <= 1'b0;
      direction     <= 1'b0;
      module_enable <= 1'b0;
      vref_level    <= 4'd0;
      done          <= 1'b0;
      steps_done    <= '0;
    end else begin
      state         <= state_n;
      period        <= period_n;
      cnt           <= cnt_n;
      remaining     <= remaining_n;
      ramp_steps    <= ramp_steps_n;
      hold_cnt      <= hold_cnt_n;
      abort_pend    <= abort_pend_n;
      rotate_pulse  <= rotate_n;
      direction     <= direction_n;
      module_enable <= enable_n;
      vref_level    <= vref_n;
      done          <= done_n;
      steps_done    <= steps_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    period_n     = period;
    cnt_n        = cnt;
    remaining_n  = remaining;
    ramp_steps_n = ramp_steps;
    hold_cnt_n   = hold_cnt;
    abort_pend_n = abort_pend;
    rotate_n     = rotate_pulse;
    direction_n  = direction;
    enable_n     = module_enable;
    vref_n       = vref_level;
    done_n       = 1'b0;
    steps_done_n = steps_done;
    rem_dec      = remaining - 1'b1;
    ramp_eff     = (state == ACCEL) ? ramp_steps + 1'b1 : ramp_steps;

    case (state)
      ACCEL, CRUISE, DECEL: begin
        if (ramping && abort) abort_pend_n = 1'b1;
        if (cnt == period - 1'b1) begin
          cnt_n        = '0;
          rotate_n     = ~rotate_pulse;
          steps_done_n = steps_done + 1'b1;
          ramp_steps_n = ramp_eff;
          // An abort sampled on the step edge itself counts as already pending.
          if (ramping && (abort_pend || abort)) begin
            if (ramp_eff < rem_dec) rem_dec = ramp_eff;
            abort_pend_n = 1'b0;
          end
          remaining_n = rem_dec;
          if (rem_dec == '0) begin
            done_n = 1'b1;
            if (HOLD_CYCLES == 0) begin
              state_n  = IDLE;
              enable_n = 1'b0;
              vref_n   = 4'd0;
            end else begin
              state_n    = HOLD;
              hold_cnt_n = HOLD_LOAD;
              vref_n     = HOLD_VREF;
            end
          end else if (ramping && (rem_dec <= ramp_eff)) begin
            state_n  = DECEL;
            period_n = per_up;
          end else if (state == ACCEL) begin
            period_n = per_down;
            if (per_down == MIN_P) state_n = CRUISE;
          end else if (state == DECEL) begin
            period_n = per_up;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_n  = IDLE;
          enable_n = 1'b0;
          vref_n   = 4'd0;
        end else begin
          hold_cnt_n = hold_cnt - 1'b1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      if (cmd_steps == '0) begin
        done_n = 1'b1;
      end else begin
        state_n      = ACCEL;
        period_n     = START_P;
        cnt_n        = '0;
        remaining_n  = cmd_steps;
        ramp_steps_n = '0;
        steps_done_n = '0;
        abort_pend_n = 1'b0;
        direction_n  = cmd_dir;
        enable_n     = 1'b1;
        vref_n       = RUN_VREF;
      end
    end
  end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// tb/tb_stepper_move_sequencer.sv - scoreboard bench for stepper_move_sequencer
module tb_stepper_move_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic        rotate_pulse;
  logic        direction;
  logic        module_enable;
  logic [3:0]  vref_level;
  logic        busy;
  logic        done;
  logic [15:0] steps_done;

  stepper_move_sequencer #(
    .START_PERIOD(10), .MIN_PERIOD(4), .ACCEL_DELTA(2), .STEP_W(16),
    .HOLD_CYCLES(20), .RUN_VREF(4'd3), .HOLD_VREF(4'd1)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .abort(abort),
    .rotate_pulse(rotate_pulse), .direction(direction),
    .module_enable(module_enable), .vref_level(vref_level), .busy(busy),
    .done(done), .steps_done(steps_done)
  );

  always #5 clk = ~clk;

  typedef struct { bit first; int iv; } tog_t;
  typedef struct { int cyc; int steps; } done_t;

  int    cyc = 0;
  int    vectors = 0;
  int    fails = 0;
  int    acc_cyc = 0;
  int    last_tog = 0;
  logic  prev_rot = 1'b0;
  int    plan[$];
  tog_t  tq[$];
  done_t dq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: pops expected step intervals and done events as the DUT presents them.
  always @(negedge clk) begin
    tog_t  t;
    done_t d;
    if (rst) begin
      prev_rot = rotate_pulse;
    end else begin
      if (rotate_pulse !== prev_rot) begin
        if (tq.size() == 0) begin
          chk("unexpected_toggle", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          t = tq.pop_front();
          chk("step_interval", 32'(t.first ? cyc - acc_cyc : cyc - last_tog), 32'(t.iv));
        end
        last_tog = cyc;
        prev_rot = rotate_pulse;
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(d.cyc));
          chk("done_steps", 32'(steps_done), 32'(d.steps));
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic send(input int steps, input bit dir, input bit exp_done,
                      input int exp_steps, output int e0, output int dcyc);
    int sum;
    @(negedge clk);
    chk("ready_before_accept", 32'(cmd_ready), 32'd1);
    e0 = cyc + 1;
    acc_cyc = e0;
    sum = 0;
    foreach (plan[i]) begin
      tq.push_back('{first: (i == 0), iv: plan[i]});
      sum += plan[i];
    end
    dcyc = e0 + sum;
    if (exp_done) dq.push_back('{cyc: dcyc, steps: exp_steps});
    cmd_steps = 16'(steps);
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int e0, d;
    logic rot_snap;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rotate", 32'(rotate_pulse), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_direction", 32'(direction), 32'd0);
    chk("rst_enable", 32'(module_enable), 32'd0);
    chk("rst_vref", 32'(vref_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_steps_done", 32'(steps_done), 32'd0);

    // Full 10-step ramp, then hold timing.
    plan = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
    send(10, 1'b1, 1'b1, 10, e0, d);
    chk("a_direction", 32'(direction), 32'd1);
    chk("a_enable", 32'(module_enable), 32'd1);
    chk("a_vref_run", 32'(vref_level), 32'd3);
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_ready_low", 32'(cmd_ready), 32'd0);
    chk("a_done_at_64", 32'(d - e0), 32'd64);
    wait_cyc(d);
    chk("a_busy_fall", 32'(busy), 32'd0);
    chk("a_ready_hold", 32'(cmd_ready), 32'd1);
    chk("a_vref_hold", 32'(vref_level), 32'd1);
    wait_cyc(d + 19);
    chk("a_hold_last_vref", 32'(vref_level), 32'd1);
    chk("a_hold_last_en", 32'(module_enable), 32'd1);
    wait_cyc(d + 20);
    chk("a_idle_vref", 32'(vref_level), 32'd0);
    chk("a_idle_en", 32'(module_enable), 32'd0);

    // Short 3-step move never reaches cruise.
    plan = '{10, 8, 10};
    send(3, 1'b0, 1'b1, 3, e0, d);
    chk("b_direction", 32'(direction), 32'd0);
    wait_cyc(d + 20);

    // 1-step move, then a new command accepted during hold.
    plan = '{10};
    send(1, 1'b1, 1'b1, 1, e0, d);
    wait_cyc(d + 3);
    chk("c_vref_hold", 32'(vref_level), 32'd1);
    plan = '{10, 8, 10};
    send(3, 1'b0, 1'b1, 3, e0, d);
    chk("c_hold_accept_vref", 32'(vref_level), 32'd3);
    chk("c_hold_accept_dir", 32'(direction), 32'd0);
    chk("c_hold_accept_busy", 32'(busy), 32'd1);
    wait_cyc(d + 20);

    // Abort pulsed during step 5 shortens the move to 8 steps.
    plan = '{10, 8, 6, 4, 4, 6, 8, 10};
    send(10, 1'b1, 1'b1, 8, e0, d);
    wait_cyc(e0 + 29);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_cyc(d + 20);

    // Zero-step command: only a done pulse.
    rot_snap = rotate_pulse;
    plan = {};
    send(0, 1'b0, 1'b1, 8, e0, d);
    chk("z_direction_kept", 32'(direction), 32'd1);
    chk("z_enable", 32'(module_enable), 32'd0);
    chk("z_vref", 32'(vref_level), 32'd0);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_rotate_kept", 32'(rotate_pulse), 32'(rot_snap));
    wait_cyc(e0 + 5);

    // Reset mid-move after step 4.
    plan = '{10, 8, 6, 4};
    send(10, 1'b1, 1'b0, 0, e0, d);
    wait_cyc(e0 + 30);
    #2 rst = 1'b1;
    #1;
    chk("r_rotate", 32'(rotate_pulse), 32'd0);
    chk("r_direction", 32'(direction), 32'd0);
    chk("r_enable", 32'(module_enable), 32'd0);
    chk("r_vref", 32'(vref_level), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_steps_done", 32'(steps_done), 32'd0);
    chk("r_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    wait_cyc(cyc + 30);

    plan = '{10, 10};
    send(2, 1'b1, 1'b1, 2, e0, d);
    wait_cyc(d + 21);

    chk("toggles_outstanding", 32'(tq.size()), 32'd0);
    chk("dones_outstanding", 32'(dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/stepper_move_sequencer.md
# stepper_move_sequencer

Motion controller that sequences a single stepper driver channel (Motor_w12 / Motor_12 / Motor_2 family). It replaces the free-running timer toggle with commanded moves. Each command is a step count and direction, executed with a linear period ramp: accelerate, cruise, decelerate. The block drives the driver's `rotate_pulse`, `direction`, `module_enable` and `vref_level` inputs, and holds the motor at reduced current for a fixed time after each move.

## Interface
Parameters:
- `START_PERIOD`, default 50000: clk cycles per step at ramp start and end; legal range ≥ `MIN_PERIOD`.
- `MIN_PERIOD`, default 13500: clk cycles per step at cruise speed; legal range ≥ 2.
- `ACCEL_DELTA`, default 4000: period change per step while ramping; legal range ≥ 1.
- `STEP_W`, default 16: width of the step count.
- `HOLD_CYCLES`, default 27000000: post-move hold duration in cycles; 0 skips hold.
- `RUN_VREF`, default 4'd3: `vref_level` while moving.
- `HOLD_VREF`, default 4'd1: `vref_level` during hold.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: move command offered.
- `cmd_ready`, out, 1: command accepted when `cmd_valid && cmd_ready` at a rising edge of `clk`.
- `cmd_steps`, in, `STEP_W`: number of steps to move.
- `cmd_dir`, in, 1: move direction.
- `abort`, in, 1: level input; requests a controlled ramp-down.
- `rotate_pulse`, out, 1: toggles once per step.
- `direction`, out, 1: latched `cmd_dir`.
- `module_enable`, out, 1: driver enable.
- `vref_level`, out, 4: driver current level.
- `busy`, out, 1: high in ACCEL, CRUISE and DECEL.
- `done`, out, 1: one-cycle pulse at the end of a move.
- `steps_done`, out, `STEP_W`: steps issued in the current or last move.

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL, HOLD.
- `cmd_ready` = (state == IDLE || state == HOLD).
- Registers:
  - `period`, width clog2(`START_PERIOD`+1).
  - `cnt`: cycle counter within the current step.
  - `remaining`, width `STEP_W`.
  - `ramp_steps`, width `STEP_W`.
  - `hold_cnt`, width clog2(`HOLD_CYCLES`+1).
  - `abort_pend`: latched abort request.
- Accept with `cmd_steps` ≠ 0:
  - State goes to ACCEL.
  - `period`=`START_PERIOD`, `cnt`=0, `remaining`=`cmd_steps`, `ramp_steps`=0, `steps_done`=0.
  - `direction`=`cmd_dir`, `module_enable`=1, `vref_level`=`RUN_VREF`.
- Accept with `cmd_steps` = 0: state, `direction` and the driver outputs are unchanged; `done` pulses on the next cycle.
- Step event: occurs when `cnt` == `period`−1. On a step event:
  - `rotate_pulse` toggles and `cnt` returns to 0.
  - `remaining`−=1 and `steps_done`+=1.
  - Let u = the period just used.
- Step evaluation, first matching rule wins:
  1. ACCEL only: `ramp_steps`+=1 before any comparison.
  2. If `abort_pend` is set (ACCEL or CRUISE): `remaining` = min(`remaining`, `ramp_steps`), then clear `abort_pend`.
  3. `remaining` == 0: go to HOLD, or to IDLE if `HOLD_CYCLES`=0. Pulse `done`.
  4. ACCEL or CRUISE with `remaining` ≤ `ramp_steps`: go to DECEL; `period` = min(u+`ACCEL_DELTA`, `START_PERIOD`).
  5. ACCEL: `period` = max(u−`ACCEL_DELTA`, `MIN_PERIOD`). If the result equals `MIN_PERIOD`, go to CRUISE.
  6. DECEL: `period` = min(u+`ACCEL_DELTA`, `START_PERIOD`).
- Abort handling:
  - `abort` sampled high in ACCEL or CRUISE sets `abort_pend`.
  - `abort` is ignored in DECEL, HOLD and IDLE.
  - Abort never cuts a step short.
- HOLD:
  - On entry, `hold_cnt`=`HOLD_CYCLES`−1 and `vref_level`=`HOLD_VREF`; `module_enable` stays 1.
  - `hold_cnt` decrements each cycle. At 0, go to IDLE with `module_enable`=0 and `vref_level`=0.
  - A command accepted in HOLD goes directly to ACCEL.
- IDLE outputs: `module_enable`=0, `vref_level`=0. `rotate_pulse` keeps its last level.
- Arithmetic: all period arithmetic is unsigned and saturating via the min/max clamps. `steps_done` and `remaining` cannot wrap because a move ends at `remaining`=0.

## Timing
- Reset values:
  - State IDLE, `cmd_ready`=1.
  - `rotate_pulse`=0, `direction`=0, `module_enable`=0, `vref_level`=0.
  - `busy`=0, `done`=0, `steps_done`=0, `abort_pend`=0.
- Reset asserted mid-move forces the reset values immediately (asynchronous). No completion `done` is issued.
- Acceptance edge is E0. `direction`, `module_enable` and `vref_level` update at E0.
- First toggle of `rotate_pulse` is at E0+`START_PERIOD`. Toggle k+1 follows toggle k by exactly the period in force after toggle k.
- `done` is registered on the same edge as the final toggle and is high for exactly one cycle. `busy` falls on that same edge.
- `direction` changes only at acceptance, never during a move, and is stable for ≥ `MIN_PERIOD` cycles before the first toggle.
- `cmd_ready` is low from E0 until the final-step edge.

## Test plan
- START=10, MIN=4, DELTA=2, HOLD_CYCLES=20, 10-step move → step intervals 10,8,6,4,4,4,4,6,8,10; `done` at E0+64; `steps_done`=10.
- Same parameters, 3-step move → intervals 10,8,10. A 1-step move → a single interval of 10 then HOLD.
- 10-step move with `abort` pulsed during step 5 → intervals 10,8,6,4,4,6,8,10; 8 steps total; `done` pulses once.
- End of move → `vref_level`=`HOLD_VREF` for 20 cycles, then `module_enable`=0 and `vref_level`=0. A new command accepted at hold cycle 5 → ACCEL with `vref_level`=`RUN_VREF` and `direction` updated at acceptance.
- `cmd_steps`=0 in IDLE → no toggle; `done` pulses once, one cycle after acceptance; outputs unchanged.
- `rst` asserted after step 4 of a 10-step move → all outputs take their reset values immediately and `done` never pulses. After release, a 2-step move runs with intervals 10,10.
